xbar_rr_fabric: RTL and testbench

- Parametrised N_IN x N_OUT crossbar for the switch datapath; successor to the fixed 4x4 slot-stamped mux fabric.
- Each input presents a payload, a destination index and a valid bit.
- Each output has a round-robin arbiter and a one-entry output register with a valid/ready handshake, so contending inputs are back-pressured instead of overwritten.
- Each output word is stamped with the source index and the current slot.

---
 rtl/xbar_pkg.sv | 31 +++
 rtl/xbar_rr_fabric_rr_arbiter.sv | 43 ++++
 rtl/xbar_rr_fabric.sv | 153 +++++++++++++++
 tb/tb_xbar_rr_fabric.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// ---------------------------------------------------------------------------
// xbar_pkg
// Shared width helpers and field layout for the round-robin crossbar.
// Output word layout, MSB to LSB: {src, slot, pld}.
// ---------------------------------------------------------------------------
package xbar_pkg;

    localparam int PLD_LSB = 0;
    localparam int PTR_RST = 0;

    function automatic int dst_w(input int n_out);
        return $clog2(n_out);
    endfunction

    function automatic int src_w(input int n_in);
        return $clog2(n_in);
    endfunction

    function automatic int out_w(input int n_in, input int pld_w, input int slot_w);
        return pld_w + slot_w + $clog2(n_in);
    endfunction

    function automatic int slot_lsb(input int pld_w);
        return pld_w;
    endfunction

    function automatic int src_lsb(input int pld_w, input int slot_w);
        return pld_w + slot_w;
    endfunction

endpackage

// File: rtl/xbar_rr_fabric_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Scans req upward from ptr with
// wrap-around and grants the first requester. The pointer register is
// owned by the caller.
// Ports:
//   req  in  N   request vector
//   en   in  1   grant allowed this cycle
//   ptr  in  IW  index with highest priority
//   gnt  out N   one-hot grant (all zero when en is low or no request)
//   idx  out IW  binary index of the winner (0 when no grant)
// N must be a power of two so that ptr + k wraps naturally.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = ptr + IW'(k);
            if (en && !found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/xbar_rr_fabric.sv
// ---------------------------------------------------------------------------
// xbar_rr_fabric
// N_IN x N_OUT crossbar with a round-robin arbiter and a one-entry output
// register per output. Losers are back-pressured through in_rdy. Each
// accepted word is stamped with its source index and the current slot.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active low
//   clr       in   synchronous flush of output registers and pointers
//   slot      in   slot number captured into accepted words
//   in_pld    in   payload per input, input i at [i*PLD_W +: PLD_W]
//   in_dst    in   destination output per input
//   in_vld    in   input valid
//   in_rdy    out  input accepted this cycle
//   out_data  out  output words {src, slot, pld}
//   out_vld   out  output register holds an unconsumed word
//   out_rdy   in   consumer takes the output word this cycle
//   cont_cnt  out  per-output 16-bit saturating contention counter
//                  (only with XBAR_RR_CONTENTION_CNT_EN defined)
// ---------------------------------------------------------------------------
module xbar_rr_fabric
    import xbar_pkg::*;
#(
    parameter  int N_IN     = 4,
    parameter  int N_OUT    = 4,
    parameter  int PLD_W    = 8,
    parameter  int SLOT_W   = 2,
    localparam int DST_W    = dst_w(N_OUT),
    localparam int SRC_W    = src_w(N_IN),
    localparam int OUT_W    = out_w(N_IN, PLD_W, SLOT_W),
    localparam int SLOT_LSB = slot_lsb(PLD_W),
    localparam int SRC_LSB  = src_lsb(PLD_W, SLOT_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [SLOT_W-1:0]      slot,
    input  logic [N_IN*PLD_W-1:0]  in_pld,
    input  logic [N_IN*DST_W-1:0]  in_dst,
    input  logic [N_IN-1:0]        in_vld,
    output logic [N_IN-1:0]        in_rdy,
    output logic [N_OUT*OUT_W-1:0] out_data,
    output logic [N_OUT-1:0]       out_vld,
    input  logic [N_OUT-1:0]       out_rdy
`ifdef XBAR_RR_CONTENTION_CNT_EN
    ,
    output logic [N_OUT*16-1:0]    cont_cnt
`endif
);

    logic [N_OUT-1:0][N_IN-1:0]  req;
    logic [N_OUT-1:0][N_IN-1:0]  gnt;
    logic [N_OUT-1:0][SRC_W-1:0] win;
    logic [N_OUT-1:0][SRC_W-1:0] ptr;
    logic [N_OUT-1:0][OUT_W-1:0] word;
    logic [N_OUT-1:0][OUT_W-1:0] data_q;
    logic [N_OUT-1:0]            vld_q;
    logic [N_OUT-1:0]            load_ok;

    always_comb begin
        req = '0;
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                req[j][i] = in_vld[i] && (in_dst[i*DST_W +: DST_W] == DST_W'(j));
            end
        end
    end

    // An output may load when empty or when its word leaves this same cycle.
    // Reset and clr block all grants so nothing is accepted and then dropped.
    always_comb begin
        load_ok = '0;
        for (int j = 0; j < N_OUT; j++) begin
            load_ok[j] = (!vld_q[j] || out_rdy[j]) && !clr && rst;
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_arb
        rr_arbiter #(.N(N_IN)) u_arb (
            .req (req[j]),
            .en  (load_ok[j]),
            .ptr (ptr[j]),
            .gnt (gnt[j]),
            .idx (win[j])
        );
    end

    // Each input requests one output only, so OR-ing grant columns is safe.
    always_comb begin
        in_rdy = '0;
        for (int j = 0; j < N_OUT; j++) begin
            in_rdy = in_rdy | gnt[j];
        end
    end

    always_comb begin
        word = '0;
        for (int j = 0; j < N_OUT; j++) begin
            word[j][PLD_LSB +: PLD_W]   = in_pld[win[j]*PLD_W +: PLD_W];
            word[j][SLOT_LSB +: SLOT_W] = slot;
            word[j][SRC_LSB +: SRC_W]   = win[j];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            data_q <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                ptr[j] <= SRC_W'(PTR_RST);
            end
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (clr) begin
                    vld_q[j]  <= 1'b0;
                    data_q[j] <= '0;
                    ptr[j]    <= SRC_W'(PTR_RST);
                end else if (|gnt[j]) begin
                    vld_q[j]  <= 1'b1;
                    data_q[j] <= word[j];
                    ptr[j]    <= win[j] + 1'b1;
                end else if (out_rdy[j]) begin
                    // data is left in place; only valid drops
                    vld_q[j]  <= 1'b0;
                end
            end
        end
    end

    assign out_data = data_q;
    assign out_vld  = vld_q;

`ifdef XBAR_RR_CONTENTION_CNT_EN
    logic [N_OUT-1:0][15:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (clr) begin
                    cnt_q[j] <= '0;
                end else if ((|(req[j] & ~gnt[j])) && (cnt_q[j] != 16'hFFFF)) begin
                    cnt_q[j] <= cnt_q[j] + 16'd1;
                end
            end
        end
    end

    assign cont_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_xbar_rr_fabric.sv
module tb_xbar_rr_fabric;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 4;
    localparam int PLD_W  = 8;
    localparam int SLOT_W = 2;
    localparam int DST_W  = 2;
    localparam int SRC_W  = 2;
    localparam int OUT_W  = 12;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clr;
    logic [SLOT_W-1:0]      slot;
    logic [N_IN*PLD_W-1:0]  in_pld;
    logic [N_IN*DST_W-1:0]  in_dst;
    logic [N_IN-1:0]        in_vld;
    logic [N_IN-1:0]        in_rdy;
    logic [N_OUT*OUT_W-1:0] out_data;
    logic [N_OUT-1:0]       out_vld;
    logic [N_OUT-1:0]       out_rdy;
`ifdef XBAR_RR_CONTENTION_CNT_EN
    logic [N_OUT*16-1:0]    cont_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [OUT_W-1:0] sb_q[$];
    logic [OUT_W-1:0] exp_w;
    logic [OUT_W-1:0] got_w;

    always #5 clk = ~clk;

    xbar_rr_fabric #(
        .N_IN(N_IN), .N_OUT(N_OUT), .PLD_W(PLD_W), .SLOT_W(SLOT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .slot     (slot),
        .in_pld   (in_pld),
        .in_dst   (in_dst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy)
`ifdef XBAR_RR_CONTENTION_CNT_EN
        ,
        .cont_cnt (cont_cnt)
`endif
    );

    function automatic logic [OUT_W-1:0] mkword(input int src, input int slt, input int pld);
        return {SRC_W'(src), SLOT_W'(slt), PLD_W'(pld)};
    endfunction

    function automatic logic [OUT_W-1:0] out_word(input int j);
        return out_data[j*OUT_W +: OUT_W];
    endfunction

    task automatic set_in(input int i, input int dst, input int pld);
        in_dst[i*DST_W +: DST_W] = DST_W'(dst);
        in_pld[i*PLD_W +: PLD_W] = PLD_W'(pld);
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; slot = '0;
        in_vld = '0; in_dst = '0; in_pld = '0; out_rdy = '1;
        repeat (2) @(posedge clk);
        #1;
        in_vld = 4'b1111;
        #1;
        n_checks++;
        if (in_rdy !== 4'b0000) begin
            n_fail++; $display("FAIL rdy_during_reset: got %b expected 0000", in_rdy);
        end
        in_vld = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_vld !== 4'b0000) begin
            n_fail++; $display("FAIL reset_out_vld: got %b expected 0000", out_vld);
        end
        n_checks++;
        if (out_data !== '0) begin
            n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
        n_checks++;
        if (in_rdy !== 4'b0000) begin
            n_fail++; $display("FAIL reset_in_rdy: got %b expected 0000", in_rdy);
        end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        set_in(2, 1, 8'hA5);
        in_vld = 4'b0100; slot = 2'd3; out_rdy = 4'hF;
        #1;
        n_checks++;
        if (in_rdy !== 4'b0100) begin
            n_fail++; $display("FAIL single_in_rdy: got %b expected 0100", in_rdy);
        end
        sb_q.push_back(mkword(2, 3, 8'hA5));
        @(posedge clk); #1;
        in_vld = '0; slot = '0;
        #1;
        exp_w = sb_q.pop_front();
        n_checks++;
        if (out_vld !== 4'b0010) begin
            n_fail++; $display("FAIL single_out_vld: got %b expected 0010", out_vld);
        end
        got_w = out_word(1);
        n_checks++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL single_out_data: got %h expected %h", got_w, exp_w);
        end
        @(posedge clk); #2;
        n_checks++;
        if (out_vld !== 4'b0000) begin
            n_fail++; $display("FAIL single_drain_vld: got %b expected 0000", out_vld);
        end
        got_w = out_word(1);
        n_checks++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL single_sticky_data: got %h expected %h", got_w, exp_w);
        end
    endtask

    task automatic test_contention();
        int order[6];
        order = '{0, 1, 3, 0, 1, 3};
        @(posedge clk); #1;
        set_in(0, 0, 8'h10); set_in(1, 0, 8'h11); set_in(3, 0, 8'h13);
        in_vld = 4'b1011; out_rdy = 4'hF;
        for (int k = 0; k < 6; k++) begin
            slot = SLOT_W'(k);
            #1;
            n_checks++;
            if (in_rdy !== (4'b0001 << order[k])) begin
                n_fail++;
                $display("FAIL cont_grant[%0d]: got %b expected input %0d", k, in_rdy, order[k]);
            end
            sb_q.push_back(mkword(order[k], k, 16 + order[k]));
            @(posedge clk); #1;
            exp_w = sb_q.pop_front();
            got_w = out_word(0);
            n_checks++;
            if (out_vld[0] !== 1'b1 || got_w !== exp_w) begin
                n_fail++;
                $display("FAIL cont_out[%0d]: got vld=%b data=%h expected vld=1 data=%h",
                         k, out_vld[0], got_w, exp_w);
            end
        end
        in_vld = '0;
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] held;
        @(posedge clk); #1;
        set_in(0, 3, 8'h33);
        in_vld = 4'b0001; slot = 2'd1; out_rdy = 4'b0111;
        #1;
        n_checks++;
        if (in_rdy !== 4'b0001) begin
            n_fail++; $display("FAIL bp_fill_rdy: got %b expected 0001", in_rdy);
        end
        sb_q.push_back(mkword(0, 1, 8'h33));
        @(posedge clk); #1;
        set_in(1, 3, 8'h44);
        in_vld = 4'b0010;
        held = sb_q.pop_front();
        for (int s = 0; s < 4; s++) begin
            slot = SLOT_W'(s + 2);
            #1;
            got_w = out_word(3);
            n_checks++;
            if (in_rdy[1] !== 1'b0 || out_vld[3] !== 1'b1 || got_w !== held) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got rdy1=%b vld3=%b data=%h expected 0 1 %h",
                         s, in_rdy[1], out_vld[3], got_w, held);
            end
            @(posedge clk); #1;
        end
        out_rdy = 4'hF; slot = 2'd2;
        #1;
        n_checks++;
        if (in_rdy !== 4'b0010) begin
            n_fail++; $display("FAIL bp_passthru_rdy: got %b expected 0010", in_rdy);
        end
        sb_q.push_back(mkword(1, 2, 8'h44));
        @(posedge clk); #1;
        in_vld = '0;
        #1;
        exp_w = sb_q.pop_front();
        got_w = out_word(3);
        n_checks++;
        if (out_vld[3] !== 1'b1 || got_w !== exp_w) begin
            n_fail++;
            $display("FAIL bp_passthru_data: got vld=%b data=%h expected vld=1 data=%h",
                     out_vld[3], got_w, exp_w);
        end
    endtask

    task automatic test_parallel_clear();
        @(posedge clk); #1;
        for (int i = 0; i < N_IN; i++) set_in(i, i ^ 1, 8'h50 + i);
        in_vld = 4'hF; out_rdy = 4'hF; slot = 2'd2;
        #1;
        n_checks++;
        if (in_rdy !== 4'hF) begin
            n_fail++; $display("FAIL par_in_rdy: got %b expected 1111", in_rdy);
        end
        for (int j = 0; j < N_OUT; j++) sb_q.push_back(mkword(j ^ 1, 2, 8'h50 + (j ^ 1)));
        @(posedge clk); #1;
        clr = 1'b1;
        #1;
        n_checks++;
        if (out_vld !== 4'hF) begin
            n_fail++; $display("FAIL par_out_vld: got %b expected 1111", out_vld);
        end
        for (int j = 0; j < N_OUT; j++) begin
            exp_w = sb_q.pop_front();
            got_w = out_word(j);
            n_checks++;
            if (got_w !== exp_w) begin
                n_fail++; $display("FAIL par_out_data[%0d]: got %h expected %h", j, got_w, exp_w);
            end
        end
        n_checks++;
        if (in_rdy !== 4'b0000) begin
            n_fail++; $display("FAIL clr_in_rdy: got %b expected 0000", in_rdy);
        end
        @(posedge clk); #1;
        clr = 1'b0; in_vld = '0;
        #1;
        n_checks++;
        if (out_vld !== 4'b0000) begin
            n_fail++; $display("FAIL clr_out_vld: got %b expected 0000", out_vld);
        end
        n_checks++;
        if (out_data !== '0) begin
            n_fail++; $display("FAIL clr_out_data: got %h expected 0", out_data);
        end
        // output 0 pointer was 2 before clr; after clr input 1 must beat input 2
        set_in(1, 0, 8'h71); set_in(2, 0, 8'h72);
        in_vld = 4'b0110;
        #1;
        n_checks++;
        if (in_rdy !== 4'b0010) begin
            n_fail++; $display("FAIL clr_ptr_reset: got %b expected 0010", in_rdy);
        end
        @(posedge clk); #1;
        in_vld = '0;
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        set_in(0, 2, 8'h66);
        in_vld = 4'b0001; out_rdy = 4'b1011; slot = 2'd1;
        #1;
        n_checks++;
        if (in_rdy !== 4'b0001) begin
            n_fail++; $display("FAIL ar_fill_rdy: got %b expected 0001", in_rdy);
        end
        sb_q.push_back(mkword(0, 1, 8'h66));
        @(posedge clk); #1;
        exp_w = sb_q.pop_front();
        for (int s = 0; s < 5; s++) begin
            #1;
            n_checks++;
            if (in_rdy !== 4'b0000) begin
                n_fail++; $display("FAIL ar_stall_rdy[%0d]: got %b expected 0000", s, in_rdy);
            end
            @(posedge clk); #1;
        end
        got_w = out_word(2);
        n_checks++;
        if (out_vld[2] !== 1'b1 || got_w !== exp_w) begin
            n_fail++;
            $display("FAIL ar_held: got vld=%b data=%h expected vld=1 data=%h",
                     out_vld[2], got_w, exp_w);
        end
`ifdef XBAR_RR_CONTENTION_CNT_EN
        n_checks++;
        if (cont_cnt[2*16 +: 16] !== 16'd5) begin
            n_fail++; $display("FAIL cnt_before_reset: got %0d expected 5", cont_cnt[2*16 +: 16]);
        end
`endif
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_vld !== 4'b0000) begin
            n_fail++; $display("FAIL ar_out_vld: got %b expected 0000", out_vld);
        end
        n_checks++;
        if (out_data !== '0) begin
            n_fail++; $display("FAIL ar_out_data: got %h expected 0", out_data);
        end
        n_checks++;
        if (in_rdy !== 4'b0000) begin
            n_fail++; $display("FAIL ar_in_rdy: got %b expected 0000", in_rdy);
        end
`ifdef XBAR_RR_CONTENTION_CNT_EN
        n_checks++;
        if (cont_cnt !== '0) begin
            n_fail++; $display("FAIL cnt_after_reset: got %h expected 0", cont_cnt);
        end
`endif
        in_vld = '0;
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_vld !== 4'b0000) begin
            n_fail++; $display("FAIL ar_idle_after: got %b expected 0000", out_vld);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_parallel_clear();
        test_async_reset();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
